sample_frame_tx: RTL

Transmit side of the hydrophone sample stream. Accepts one 4-channel frame of 16-bit samples per input handshake, buffers it, and emits it as a 32-bit AXI4-Stream master: two beats per frame, with `tlast` on the second beat. The stream is in the exact format the max-finding receiver consumes, so this block can drive it directly or act as a bench/loopback source.

---
 rtl/sample_stream_pkg.sv | 26 ++
 rtl/frame_fifo.sv | 55 +++++
 rtl/sample_frame_tx.sv | 85 ++++++++
 3 files changed

// File: rtl/sample_stream_pkg.sv
// Shared types for the hydrophone sample stream (transmit and receive sides).
package sample_stream_pkg;

  localparam int NUM_CHANNELS    = 4;
  localparam int SAMPLE_WIDTH    = 16;
  localparam int BEATS_PER_FRAME = 2;

  // ch0 occupies the least significant bits.
  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] ch3;
    logic [SAMPLE_WIDTH-1:0] ch2;
    logic [SAMPLE_WIDTH-1:0] ch1;
    logic [SAMPLE_WIDTH-1:0] ch0;
  } frame_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_BEAT0 = 2'd1,
    TX_BEAT1 = 2'd2
  } tx_state_t;

  function automatic logic [2*SAMPLE_WIDTH-1:0] beat_word(input frame_t f, input logic second);
    return second ? {f.ch3, f.ch2} : {f.ch1, f.ch0};
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous frame FIFO; pointers carry a wrap bit so full and empty are unambiguous.
module frame_fifo
  import sample_stream_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  frame_t                 push_data,
  input  logic                   pop,
  output frame_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  frame_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/sample_frame_tx.sv
// Buffers 4-channel sample frames and emits each as two 32-bit AXI4-Stream beats.
module sample_frame_tx
  import sample_stream_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 2,
  parameter int COUNT_WIDTH          = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_aresetn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SAMPLE_WIDTH-1:0]         in_ch0,
  input  logic [SAMPLE_WIDTH-1:0]         in_ch1,
  input  logic [SAMPLE_WIDTH-1:0]         in_ch2,
  input  logic [SAMPLE_WIDTH-1:0]         in_ch3,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [COUNT_WIDTH-1:0]          frame_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t             state_q, state_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                  ready_en_q;
  frame_t                in_frame, head;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push, pop;

  assign in_frame = '{ch3: in_ch3, ch2: in_ch2, ch1: in_ch1, ch0: in_ch0};
  assign in_ready = ready_en_q & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == TX_BEAT1) & m_axis_tready;

  frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (m_axis_aclk),
    .rst_n     (m_axis_aresetn),
    .push      (push),
    .push_data (in_frame),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Looking at the push lets a frame into an idle block show BEAT0 one edge after acceptance.
  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    case (state_q)
      TX_IDLE:  if (!fifo_empty || push) state_d = TX_BEAT0;
      TX_BEAT0: if (m_axis_tready) state_d = TX_BEAT1;
      TX_BEAT1: if (m_axis_tready) begin
        frame_count_d = frame_count_q + COUNT_WIDTH'(1);
        state_d       = (fifo_count > CNT_W'(1) || push) ? TX_BEAT0 : TX_IDLE;
      end
      default:  state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      state_q       <= TX_IDLE;
      frame_count_q <= '0;
      ready_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      ready_en_q    <= 1'b1;
    end
  end

  // Head only moves on the BEAT1 pop, so beat data is stable under backpressure.
  assign m_axis_tvalid = (state_q != TX_IDLE);
  assign m_axis_tlast  = (state_q == TX_BEAT1);
  assign m_axis_tdata  = m_axis_tvalid ? C_M_AXIS_TDATA_WIDTH'(beat_word(head, m_axis_tlast))
                                       : '0;
  assign frame_count   = frame_count_q;

endmodule
